// File: rtl/instr_pkg.sv
// ---------------------------------------------------------------------------
// instr_pkg : opcode constants, instruction field positions and the loader
//             state encoding shared by the loader and the instruction decoder.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instr_pkg;

   localparam logic [5:0] OP_ALU_MAX    = 6'd7;
   localparam logic [5:0] OP_BRANCH     = 6'd8;
   localparam logic [5:0] OP_JUMP       = 6'd9;
   localparam logic [5:0] OP_LAST_LEGAL = 6'd9;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_word_fifo.sv
// ---------------------------------------------------------------------------
// instr_word_fifo : 2-entry 32-bit synchronous FIFO with push/pop/count.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_word_fifo (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  logic [31:0] i_wdata,
   input  logic        i_pop,
   output logic [31:0] o_head,
   output logic [1:0]  o_count
);

   logic [31:0] r_mem [2];
   logic        r_rd_ptr;
   logic        r_wr_ptr;
   logic [1:0]  r_count;
   logic        w_push;
   logic        w_pop;

   assign w_push  = i_push && (r_count != 2'd2);
   assign w_pop   = i_pop  && (r_count != 2'd0);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_program_loader.sv
// ---------------------------------------------------------------------------
// instr_program_loader : packs field-level instruction beats into 32-bit words
//                        and writes them sequentially into instruction memory.
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_program_loader
   import instr_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic              overflow,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W+1:0] c_CAP  = {2'b01, {ADDR_W{1'b0}}};

   function automatic logic [31:0] f_encode(
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [15:0] imm
   );
      logic [31:0] w;
      w = '0;
      w[OPC_MSB:OPC_LSB] = op;
      if (op <= OP_ALU_MAX) begin
         w[RS_MSB:RS_LSB] = rs;
         w[RT_MSB:RT_LSB] = rt;
         w[RD_MSB:RD_LSB] = rd;
      end else if (op == OP_BRANCH) begin
         w[RS_MSB:RS_LSB]   = rs;
         w[RT_MSB:RT_LSB]   = rt;
         w[IMM_MSB:IMM_LSB] = imm;
      end else if (op == OP_JUMP) begin
         w[IMM_MSB:IMM_LSB] = imm;
      end
      return w;
   endfunction

   loader_state_e     r_state;
   loader_state_e     w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_illegal;
   logic              r_overflow;
   logic              r_busy;
   logic              r_done;

   logic [1:0]        w_occ;
   logic [31:0]       w_head;
   logic              w_accept;
   logic              w_legal;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_start_load;
   logic [ADDR_W+1:0] w_fill;

   // Words in memory plus words still buffered: invariant under a pop.
   assign w_fill       = {1'b0, r_count} + {{ADDR_W{1'b0}}, w_occ};
   assign w_full       = (w_fill == c_CAP);
   assign w_legal      = (in_opcode <= OP_LAST_LEGAL);
   assign in_ready     = (r_state == ST_LOAD) && (w_occ != 2'd2);
   assign w_accept     = in_valid && in_ready;
   assign w_push       = w_accept && w_legal && !w_full;
   assign w_pop        = mem_we && mem_ready;
   assign w_start_load = (r_state == ST_IDLE) && start;

   instr_word_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (f_encode(in_opcode, in_rs, in_rt, in_rd, in_imm)),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_occ)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_LOAD;
         ST_LOAD:  if (w_accept && in_last) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_occ == 2'd0) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_addr     <= c_BASE;
         r_count    <= '0;
         r_illegal  <= 1'b0;
         r_overflow <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_DRAIN);
         r_done  <= (w_state_nxt == ST_DONE);
         if (w_start_load) begin
            r_addr     <= c_BASE;
            r_count    <= '0;
            r_illegal  <= 1'b0;
            r_overflow <= 1'b0;
         end else begin
            if (w_pop) begin
               r_addr  <= r_addr + 1'b1;
               r_count <= r_count + 1'b1;
            end
            if (w_accept && !w_legal) r_illegal <= 1'b1;
            if (w_accept && w_full)   r_overflow <= 1'b1;
         end
      end
   end

   assign mem_we    = (w_occ != 2'd0);
   assign mem_wdata = w_head;
   assign mem_addr  = r_addr;
   assign count     = r_count;
   assign busy      = r_busy;
   assign done      = r_done;
   assign illegal   = r_illegal;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_instr_program_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_program_loader : bench for instr_program_loader (ADDR_W=8 and 2).
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_program_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [5:0]  in_opcode = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
   logic [15:0] in_imm = '0;
   logic        in_last = 1'b0;
   logic        mem_ready = 1'b1;

   logic        in_ready, mem_we, busy, done, illegal, overflow;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [8:0]  count;

   logic        in_ready2, mem_we2, busy2, done2, illegal2, overflow2;
   logic [1:0]  mem_addr2;
   logic [31:0] mem_wdata2;
   logic [2:0]  count2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .busy(busy), .done(done), .illegal(illegal),
      .overflow(overflow), .count(count)
   );

   instr_program_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
      .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_last(in_last), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_ready(mem_ready), .busy(busy2), .done(done2), .illegal(illegal2),
      .overflow(overflow2), .count(count2)
   );

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic        last;
      logic [31:0] word;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] word;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
   } sb_t;

   sb_t q1[$];
   sb_t q2[$];
   int  m_fill  = 0;
   int  m2_fill = 0;
   int  n_acc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [15:0] imm);
      if (op <= 6'd7)       return {op, rs, rt, rd, 11'b0};
      else if (op == 6'd8)  return {op, rs, rt, imm};
      else                  return {op, 10'b0, imm};
   endfunction

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      m_fill = 0;
      m2_fill = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm, input logic last,
                            input logic [31:0] word);
      sb_t e;
      bit  ok = 0;
      in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         n_acc++;
         if (op <= 6'd9) begin
            e.word = word; e.op = op; e.rs = rs; e.rt = rt; e.rd = rd; e.imm = imm;
            if (m_fill < 256) begin
               e.addr = 8'(m_fill);
               q1.push_back(e);
               m_fill++;
            end
            if (m2_fill < 4) begin
               e.addr = 8'(m2_fill);
               q2.push_back(e);
               m2_fill++;
            end
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int exp1, input int exp2);
      int p1 = 0;
      int p2 = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done)  p1++;
         if (done2) p2++;
         if (p1 > 0 && p2 > 0 && !done && !done2) break;
      end
      chk({nm, "_done_pulse"}, p1, 1);
      chk({nm, "_done2_pulse"}, p2, 1);
      chk({nm, "_busy"}, {31'b0, busy}, 0);
      chk({nm, "_count"}, {23'b0, count}, exp1);
      chk({nm, "_count2"}, {29'b0, count2}, exp2);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_in_ready"}, {31'b0, in_ready}, 0);
      chk({nm, "_mem_we"}, {31'b0, mem_we}, 0);
      chk({nm, "_mem_addr"}, {24'b0, mem_addr}, 0);
      chk({nm, "_count"}, {23'b0, count}, 0);
      chk({nm, "_busy"}, {31'b0, busy}, 0);
      chk({nm, "_done"}, {31'b0, done}, 0);
      chk({nm, "_illegal"}, {31'b0, illegal}, 0);
      chk({nm, "_overflow"}, {31'b0, overflow}, 0);
      chk({nm, "_mem_we2"}, {31'b0, mem_we2}, 0);
      chk({nm, "_in_ready2"}, {31'b0, in_ready2}, 0);
      chk({nm, "_overflow2"}, {31'b0, overflow2}, 0);
      chk({nm, "_illegal2"}, {31'b0, illegal2}, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[7];
      bit   new_prog;
      int   ncnt;
      logic exp_ill;
      logic [7:0]  cap_addr;
      logic [31:0] cap_data;

      tbl[0] = '{6'd2,  5'd1,  5'd2,  5'd3,  16'hFFFF, 1'b1, 32'h08221800};
      tbl[1] = '{6'd8,  5'd4,  5'd5,  5'd0,  16'h0010, 1'b0, 32'h20850010};
      tbl[2] = '{6'd9,  5'd7,  5'd0,  5'd0,  16'h0040, 1'b0, 32'h24000040};
      tbl[3] = '{6'd7,  5'd31, 5'd31, 5'd31, 16'h0000, 1'b1, 32'h1FFFF800};
      tbl[4] = '{6'd1,  5'd3,  5'd4,  5'd5,  16'h0000, 1'b0, 32'h04642800};
      tbl[5] = '{6'd12, 5'd1,  5'd1,  5'd1,  16'h1234, 1'b0, 32'h00000000};
      tbl[6] = '{6'd8,  5'd2,  5'd3,  5'd0,  16'hABCD, 1'b1, 32'h2043ABCD};

      fork
         forever begin
            sb_t e;
            @(negedge clk);
            if (rst_n && mem_we && mem_ready) begin
               if (q1.size() == 0) begin
                  chk("unexpected_write", {24'b0, mem_addr}, 32'hFFFFFFFF);
               end else begin
                  e = q1.pop_front();
                  chk("wr_addr", {24'b0, mem_addr}, {24'b0, e.addr});
                  chk("wr_data", mem_wdata, e.word);
                  chk("dec_op", {26'b0, mem_wdata[31:26]}, {26'b0, e.op});
                  if (e.op <= 6'd7) begin
                     chk("dec_rs", {27'b0, mem_wdata[25:21]}, {27'b0, e.rs});
                     chk("dec_rt", {27'b0, mem_wdata[20:16]}, {27'b0, e.rt});
                     chk("dec_rd", {27'b0, mem_wdata[15:11]}, {27'b0, e.rd});
                  end else if (e.op == 6'd8) begin
                     chk("dec_rs", {27'b0, mem_wdata[25:21]}, {27'b0, e.rs});
                     chk("dec_rt", {27'b0, mem_wdata[20:16]}, {27'b0, e.rt});
                     chk("dec_imm", {16'b0, mem_wdata[15:0]}, {16'b0, e.imm});
                  end else begin
                     chk("dec_imm", {16'b0, mem_wdata[15:0]}, {16'b0, e.imm});
                  end
               end
            end
         end
         forever begin
            sb_t e;
            @(negedge clk);
            if (rst_n && mem_we2 && mem_ready) begin
               if (q2.size() == 0) begin
                  chk("unexpected_write2", {30'b0, mem_addr2}, 32'hFFFFFFFF);
               end else begin
                  e = q2.pop_front();
                  chk("wr_addr2", {30'b0, mem_addr2}, {24'b0, e.addr});
                  chk("wr_data2", mem_wdata2, e.word);
               end
            end
         end
      join_none

      // reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("rst");

      // table-driven programs
      new_prog = 1;
      ncnt = 0;
      exp_ill = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (new_prog) begin
            do_start();
            ncnt = 0;
            exp_ill = 1'b0;
         end
         send_beat(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].last,
                   tbl[i].word);
         if (tbl[i].op <= 6'd9) ncnt++;
         else exp_ill = 1'b1;
         new_prog = tbl[i].last;
         if (tbl[i].last) begin
            wait_done($sformatf("prog%0d", i), ncnt, ncnt);
            chk("prog_illegal", {31'b0, illegal}, {31'b0, exp_ill});
            chk("prog_end_addr", {24'b0, mem_addr}, ncnt);
         end
      end
      chk("q1_empty", q1.size(), 0);

      // backpressure: memory stalled while a 4-beat stream arrives
      mem_ready = 1'b0;
      n_acc = 0;
      do_start();
      fork
         begin
            send_beat(6'd3, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, enc(6'd3, 5'd1, 5'd2, 5'd3, 16'h0));
            send_beat(6'd8, 5'd9, 5'd10, 5'd0, 16'h1111, 1'b0,
                      enc(6'd8, 5'd9, 5'd10, 5'd0, 16'h1111));
            send_beat(6'd9, 5'd0, 5'd0, 5'd0, 16'hBEEF, 1'b0, enc(6'd9, 5'd0, 5'd0, 5'd0, 16'hBEEF));
            send_beat(6'd0, 5'd17, 5'd18, 5'd19, 16'h0, 1'b1,
                      enc(6'd0, 5'd17, 5'd18, 5'd19, 16'h0));
         end
         begin
            for (int i = 0; i < 50; i++) begin
               @(negedge clk);
               if (n_acc >= 2) break;
            end
            @(negedge clk);
            cap_addr = mem_addr;
            cap_data = mem_wdata;
            chk("stall_addr0", {24'b0, cap_addr}, 0);
            for (int i = 0; i < 5; i++) begin
               chk("stall_in_ready", {31'b0, in_ready}, 0);
               chk("stall_mem_we", {31'b0, mem_we}, 1);
               chk("stall_addr", {24'b0, mem_addr}, {24'b0, cap_addr});
               chk("stall_data", mem_wdata, cap_data);
               @(negedge clk);
            end
            @(posedge clk); #1;
            mem_ready = 1'b1;
         end
      join
      wait_done("stall", 4, 4);

      // capacity: ADDR_W=2 instance wraps and overflows on the fifth beat
      do_start();
      for (int i = 0; i < 5; i++) begin
         send_beat(6'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'h0, (i == 4),
                   enc(6'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 16'h0));
      end
      wait_done("wrap", 5, 4);
      chk("wrap_overflow2", {31'b0, overflow2}, 1);
      chk("wrap_overflow", {31'b0, overflow}, 0);
      chk("wrap_addr2", {30'b0, mem_addr2}, 0);
      chk("wrap_addr", {24'b0, mem_addr}, 5);

      // asynchronous reset in the middle of DRAIN
      mem_ready = 1'b0;
      do_start();
      send_beat(6'd15, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 32'h0);
      send_beat(6'd3, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0, enc(6'd3, 5'd4, 5'd5, 5'd6, 16'h0));
      send_beat(6'd4, 5'd7, 5'd8, 5'd9, 16'h0, 1'b1, enc(6'd4, 5'd7, 5'd8, 5'd9, 16'h0));
      @(negedge clk);
      chk("drain_busy", {31'b0, busy}, 1);
      chk("drain_illegal", {31'b0, illegal}, 1);
      chk("drain_mem_we", {31'b0, mem_we}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      q1.delete();
      q2.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ready = 1'b1;
      do_start();
      send_beat(6'd5, 5'd10, 5'd11, 5'd12, 16'h0, 1'b1, enc(6'd5, 5'd10, 5'd11, 5'd12, 16'h0));
      wait_done("post_rst", 1, 1);
      chk("post_rst_illegal", {31'b0, illegal}, 0);

      repeat (3) @(negedge clk);
      chk("q1_final_empty", q1.size(), 0);
      chk("q2_final_empty", q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
